// File: rtl/ro_multich_freq_meter_if.sv
// Result handshake of the multi-channel ring-oscillator frequency meter.
// The meter drives the master side; the UART/FSM layer consumes through the slave side.
interface ro_multich_freq_meter_if #(
  parameter int SUM_W = 19,
  parameter int CH_W  = 2
);
  logic             res_valid;
  logic             res_ready;
  logic [SUM_W-1:0] res_sum;
  logic [CH_W-1:0]  res_ch;
  logic             res_sat;

  modport master (output res_valid, res_sum, res_ch, res_sat, input res_ready);
  modport slave  (input res_valid, res_sum, res_ch, res_sat, output res_ready);
endinterface

// File: rtl/ro_multich_freq_meter.sv
// Scans masked ring-oscillator channels: settle, count 2**AVG_LOG2 windows of edges,
// and hand the summed count out on a valid/ready result port with backpressure.
module ro_multich_freq_meter #(
  parameter int NCH      = 4,
  parameter int CNT_W    = 16,
  parameter int WIN_W    = 16,
  parameter int AVG_LOG2 = 3,
  parameter int SETTLE   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   osc_in,
  output logic [NCH-1:0]   osc_en,
  input  logic [NCH-1:0]   ch_mask,
  input  logic [WIN_W-1:0] win_len,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  ro_multich_freq_meter_if.master res
);

  localparam int SUM_W = CNT_W + AVG_LOG2;
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;

  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_ACCUM,
    S_OUTPUT,
    S_NEXT
  } state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [WIN_W-1:0]   win_m1_q, win_m1_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SUM_W-1:0]   accum_q, accum_d;
  logic               res_valid_q, res_valid_d;
  logic [SUM_W-1:0]   res_sum_q, res_sum_d;
  logic [CH_W-1:0]    res_ch_q, res_ch_d;
  logic               res_sat_q, res_sat_d;
  logic [NCH-1:0]     osc_en_q, osc_en_d;

  logic [NCH-1:0]     sync1_q, sync2_q, sync3_q;
  logic [NCH-1:0]     rise;

  logic               low_found, nxt_found;
  logic [CH_W-1:0]    low_ch, nxt_ch;
  logic               enter_settle;
  logic [CH_W-1:0]    sel_ch;

  // Two flops resolve metastability, the third holds the previous level for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its source.
      sync1_q <= osc_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise = sync2_q & ~sync3_q;

  // Walking downward leaves the lowest qualifying bit as the final assignment.
  always_comb begin
    low_found = 1'b0;
    low_ch    = '0;
    nxt_found = 1'b0;
    nxt_ch    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        low_found = 1'b1;
        low_ch    = CH_W'(i);
        if (i > int'(ch_q)) begin
          nxt_found = 1'b1;
          nxt_ch    = CH_W'(i);
        end
      end
    end
  end

  always_comb begin
    // NOTE: every target gets a default first, so no path can infer a latch.
    state_d      = state_q;
    ch_d         = ch_q;
    win_m1_d     = win_m1_q;
    tmr_d        = tmr_q;
    cnt_d        = cnt_q;
    sat_d        = sat_q;
    idx_d        = idx_q;
    accum_d      = accum_q;
    res_valid_d  = res_valid_q;
    res_sum_d    = res_sum_q;
    res_ch_d     = res_ch_q;
    res_sat_d    = res_sat_q;
    enter_settle = 1'b0;
    sel_ch       = low_ch;
    osc_en_d     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start && low_found) enter_settle = 1'b1;
      end
      S_SETTLE: begin
        accum_d = '0;
        idx_d   = '0;
        cnt_d   = '0;
        sat_d   = 1'b0;
        if (tmr_q == '0) begin
          state_d = S_COUNT;
          tmr_d   = TMR_W'(win_m1_q);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_COUNT: begin
        if (rise[ch_q]) begin
          if (&cnt_q) sat_d = 1'b1;
          else        cnt_d = cnt_q + CNT_W'(1);
        end
        if (tmr_q == '0) state_d = S_ACCUM;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      S_ACCUM: begin
        accum_d = accum_q + SUM_W'(cnt_q);
        cnt_d   = '0;
        if (idx_q == IDX_LAST) begin
          state_d     = S_OUTPUT;
          res_valid_d = 1'b1;
          res_sum_d   = accum_q + SUM_W'(cnt_q);
          res_ch_d    = ch_q;
          res_sat_d   = sat_q;
        end else begin
          state_d = S_COUNT;
          idx_d   = idx_q + IDX_W'(1);
          tmr_d   = TMR_W'(win_m1_q);
        end
      end
      S_OUTPUT: begin
        if (res.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_NEXT;
        end
      end
      S_NEXT: begin
        if (nxt_found) begin
          enter_settle = 1'b1;
          sel_ch       = nxt_ch;
        end else if (continuous && low_found) begin
          enter_settle = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // win_len is sampled once per channel; zero is stretched to a 1-cycle window.
    if (enter_settle) begin
      state_d  = S_SETTLE;
      ch_d     = sel_ch;
      tmr_d    = SETTLE_LAST;
      win_m1_d = (win_len == '0) ? '0 : win_len - WIN_W'(1);
    end

    if (state_d inside {S_SETTLE, S_COUNT, S_ACCUM}) osc_en_d = NCH'(1) << ch_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      win_m1_q    <= '0;
      tmr_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      idx_q       <= '0;
      accum_q     <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_ch_q    <= '0;
      res_sat_q   <= 1'b0;
      osc_en_q    <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      win_m1_q    <= win_m1_d;
      tmr_q       <= tmr_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      idx_q       <= idx_d;
      accum_q     <= accum_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_ch_q    <= res_ch_d;
      res_sat_q   <= res_sat_d;
      osc_en_q    <= osc_en_d;
    end
  end

  assign osc_en        = osc_en_q;
  assign busy          = (state_q != S_IDLE);
  assign res.res_valid = res_valid_q;
  assign res.res_sum   = res_sum_q;
  assign res.res_ch    = res_ch_q;
  assign res.res_sat   = res_sat_q;

endmodule

// File: tb/tb_ro_multich_freq_meter.sv
// Self-checking bench: table of single-scan vectors, hand-written corner sequences,
// and randomized scans against a windows-times-edges-per-window reference model.
module tb_ro_multich_freq_meter;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  osc_in = '0;
  logic [3:0]  osc_en, osc_en_s;
  logic [3:0]  ch_mask;
  logic [15:0] win_len;
  logic        start, start_s, continuous;
  logic        busy, busy_s;

  ro_multich_freq_meter_if #(.SUM_W(19), .CH_W(2)) r_if ();
  ro_multich_freq_meter_if #(.SUM_W(7),  .CH_W(2)) s_if ();

  ro_multich_freq_meter dut (
    .clk(clk), .reset(reset), .osc_in(osc_in), .osc_en(osc_en), .ch_mask(ch_mask),
    .win_len(win_len), .start(start), .continuous(continuous), .busy(busy), .res(r_if)
  );

  ro_multich_freq_meter #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .osc_in(osc_in), .osc_en(osc_en_s), .ch_mask(ch_mask),
    .win_len(win_len), .start(start_s), .continuous(continuous), .busy(busy_s), .res(s_if)
  );

  always #5 clk = ~clk;

  // Oscillator models: period in clk cycles, 0 = stopped; one rise per period.
  int per [4];
  int ph  [4];
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (per[i] <= 0) osc_in[i] = 1'b0;
      else begin
        ph[i]     = (ph[i] + 1) % per[i];
        osc_in[i] = (ph[i] < per[i] / 2);
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Sum of 8 windows, each holding (window / period) edges, clipped at the counter max.
  function automatic int model_sum(input int w, input int p, input int cnt_max);
    int we;
    int edges;
    we    = (w == 0) ? 1 : w;
    edges = (p == 0) ? 0 : we / p;
    if (edges > cnt_max) edges = cnt_max;
    return edges * 8;
  endfunction

  typedef struct {
    logic [3:0] mask;
    int         win;
    int         p [4];
    int         exp_ch;
    int         exp_sum;
    int         exp_lat;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] m, input int w, input int p0, input int p1,
                              input int p2, input int p3, input int ch, input int sum,
                              input int lat);
    vec_t v;
    v.mask = m; v.win = w;
    v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3;
    v.exp_ch = ch; v.exp_sum = sum; v.exp_lat = lat;
    return v;
  endfunction

  int got_ch  [$];
  int got_sum [$];
  int got_sat [$];

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic drain(input string tag);
    int cyc = 0;
    r_if.res_ready = 1'b1;
    while (busy && cyc < 20000) begin
      @(negedge clk); cyc++;
    end
    r_if.res_ready = 1'b0;
    @(negedge clk);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_osc_en"}, osc_en, 0);
  endtask

  task automatic collect(input int n, input int limit, input bit rnd);
    int cyc = 0;
    got_ch.delete(); got_sum.delete(); got_sat.delete();
    while (got_ch.size() < n && cyc < limit) begin
      @(negedge clk); cyc++;
      r_if.res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (r_if.res_valid && r_if.res_ready) begin
        got_ch.push_back(int'(r_if.res_ch));
        got_sum.push_back(int'(r_if.res_sum));
        got_sat.push_back(int'(r_if.res_sat));
      end
    end
    if (got_ch.size() < n) check("collect_timeout", got_ch.size(), n);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    for (int i = 0; i < 4; i++) per[i] = v.p[i];
    ch_mask = v.mask; win_len = 16'(v.win); continuous = 1'b0; r_if.res_ready = 1'b0;
    pulse_start();
    lat = 1;
    while (!r_if.res_valid && lat < 5000) begin
      @(negedge clk); lat++;
    end
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_ch"}, r_if.res_ch, v.exp_ch);
    check({tag, "_sum"}, r_if.res_sum, v.exp_sum);
    check({tag, "_sat"}, r_if.res_sat, 0);
    check({tag, "_osc_en_out"}, osc_en, 0);
    drain(tag);
  endtask

  vec_t tbl [5];

  initial begin
    int cyc;
    int m, w, n;
    int pset [5];
    int e_ch  [$];
    int e_sum [$];

    pset = '{3, 4, 6, 8, 12};
    tbl[0] = mk(4'b0001, 80, 8, 0, 0,  0, 0, 80, 665);
    tbl[1] = mk(4'b0100, 48, 0, 0, 6,  0, 2, 64, 409);
    tbl[2] = mk(4'b1000, 24, 0, 0, 0,  3, 3, 64, 217);
    tbl[3] = mk(4'b0010,  0, 0, 0, 0,  0, 1,  0,  33);
    tbl[4] = mk(4'b0110, 30, 0, 5, 3,  0, 1, 48, 265);

    reset = 1'b1; start = 1'b0; start_s = 1'b0; continuous = 1'b0;
    ch_mask = '0; win_len = '0; r_if.res_ready = 1'b0; s_if.res_ready = 1'b0;
    #22;
    check("rst_osc_en", osc_en, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", r_if.res_valid, 0);
    check("rst_sum", r_if.res_sum, 0);
    check("rst_ch", r_if.res_ch, 0);
    check("rst_sat", r_if.res_sat, 0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Empty mask: start is ignored.
    ch_mask = '0;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mask0_busy", busy, 0);
    end

    // Narrow counter saturates in every window.
    per = '{4, 0, 0, 0}; ch_mask = 4'b0001; win_len = 16'd100; s_if.res_ready = 1'b0;
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    cyc = 0;
    while (!s_if.res_valid && cyc < 3000) begin
      @(negedge clk); cyc++;
    end
    check("sat_valid", s_if.res_valid, 1);
    check("sat_sum", s_if.res_sum, model_sum(100, 4, 15));
    check("sat_flag", s_if.res_sat, 1);
    check("sat_ch", s_if.res_ch, 0);
    s_if.res_ready = 1'b1;
    cyc = 0;
    while (busy_s && cyc < 1000) begin
      @(negedge clk); cyc++;
    end
    s_if.res_ready = 1'b0;
    check("sat_idle", busy_s, 0);

    // Two-channel single pass.
    per = '{0, 8, 0, 16}; ch_mask = 4'b1010; win_len = 16'd80; continuous = 1'b0;
    pulse_start();
    collect(2, 5000, 1'b0);
    check("pass_ch_a", got_ch[0], 1);
    check("pass_sum_a", got_sum[0], 80);
    check("pass_ch_b", got_ch[1], 3);
    check("pass_sum_b", got_sum[1], 40);
    drain("pass");

    // Continuous scan held under backpressure; a start while busy must not disturb it.
    per = '{8, 0, 0, 16}; ch_mask = 4'b1001; win_len = 16'd80; continuous = 1'b1;
    r_if.res_ready = 1'b0;
    pulse_start();
    cyc = 0;
    while (!r_if.res_valid && cyc < 2000) begin
      @(negedge clk); cyc++;
    end
    check("bp_first_ch", r_if.res_ch, 0);
    for (int c = 0; c < 500; c++) begin
      start = (c == 250);
      @(negedge clk);
      check("bp_hold", {r_if.res_valid, r_if.res_sum, osc_en}, {1'b1, 19'd80, 4'd0});
    end
    start = 1'b0;
    collect(4, 10000, 1'b0);
    check("cont_ch0", got_ch[0], 0); check("cont_sum0", got_sum[0], 80);
    check("cont_ch1", got_ch[1], 3); check("cont_sum1", got_sum[1], 40);
    check("cont_ch2", got_ch[2], 0); check("cont_sum2", got_sum[2], 80);
    check("cont_ch3", got_ch[3], 3); check("cont_sum3", got_sum[3], 40);
    continuous = 1'b0;
    drain("cont");

    // Reset in the middle of a count window.
    per = '{8, 0, 0, 0}; ch_mask = 4'b0001; win_len = 16'd80;
    pulse_start();
    repeat (100) @(negedge clk);
    check("rst_mid_running", osc_en, 4'b0001);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_osc_en", osc_en, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", r_if.res_valid, 0);
    @(negedge clk); reset = 1'b0;
    run_vec(tbl[0], "restart");

    // Randomized single-pass scans with random backpressure.
    for (int it = 0; it < 6; it++) begin
      m = int'($urandom_range(1, 15));
      w = 24 * int'($urandom_range(1, 2));
      for (int i = 0; i < 4; i++) per[i] = pset[$urandom_range(0, 4)];
      e_ch.delete(); e_sum.delete();
      for (int i = 0; i < 4; i++) begin
        if (m[i]) begin
          e_ch.push_back(i);
          e_sum.push_back(model_sum(w, per[i], 65535));
        end
      end
      n = e_ch.size();
      ch_mask = 4'(m); win_len = 16'(w); continuous = 1'b0;
      pulse_start();
      collect(n, 30000, 1'b1);
      for (int k = 0; k < n; k++) begin
        check($sformatf("rnd%0d_ch%0d", it, k), got_ch[k], e_ch[k]);
        check($sformatf("rnd%0d_sum%0d", it, k), got_sum[k], e_sum[k]);
        check($sformatf("rnd%0d_sat%0d", it, k), got_sat[k], 0);
      end
      drain($sformatf("rnd%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
